// File: rtl/serial_mag_comparator.sv
// ---------------------------------------------------------------------------
// serial_mag_comparator
//
// Bit-serial magnitude comparator. Two WIDTH-bit operands A and B arrive one
// bit pair per beat, MSB first. After the last beat the block presents one
// result (eq / gt / lt) and holds it until the consumer takes it.
//
// Handshake semantics (both sides): a transfer happens on a rising clk edge
// where valid and ready are both 1. A producer may not retract valid or change
// its payload while waiting. in_ready never depends on in_valid, and out_valid
// never depends on out_ready. Both are driven directly from flops.
//
// Ports
//   clk        in   clock, all state changes on the rising edge
//   rst_n      in   asynchronous active-low reset
//   clr        in   synchronous abort of the word in progress or the pending result
//   in_valid   in   a_bit / b_bit carry a valid bit pair
//   in_ready   out  block accepts a bit pair this cycle
//   a_bit      in   current bit of A (MSB first)
//   b_bit      in   current bit of B (MSB first)
//   out_valid  out  result valid, held until accepted
//   out_ready  in   consumer accepts the result
//   eq/gt/lt   out  comparison result, one-hot while out_valid=1, else 0
//   dbg_state  out  FSM state (0 = COLLECT, 1 = DONE)
//   dbg_cnt    out  beat counter
// ---------------------------------------------------------------------------
module serial_mag_comparator #(
  parameter int WIDTH = 8
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       clr,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic                       a_bit,
  input  logic                       b_bit,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic                       eq,
  output logic                       gt,
  output logic                       lt,
  output logic                       dbg_state,
  output logic [$clog2(WIDTH)-1:0]   dbg_cnt
);

  localparam int                 CNT_W    = $clog2(WIDTH);
  localparam logic [CNT_W-1:0]   LAST_CNT = CNT_W'(WIDTH - 1);

  typedef enum logic {
    ST_COLLECT = 1'b0,
    ST_DONE    = 1'b1
  } state_e;

  state_e           state_q;
  logic [CNT_W-1:0] cnt_q;
  // Sticky decision: 2'b10 = A>B, 2'b01 = A<B, 2'b00 = undecided so far.
  logic [1:0]       dec_q;
  logic             in_ready_q;
  logic             out_valid_q;
  logic             eq_q;
  logic             gt_q;
  logic             lt_q;

  logic             beat;
  logic             last_beat;
  logic [1:0]       dec_d;

  always_comb begin
    beat      = in_valid & in_ready_q;
    last_beat = (cnt_q == LAST_CNT);
    // The first differing bit pair is the most significant one, so once a
    // decision exists, later bits are ignored.
    dec_d     = dec_q;
    if (dec_q == 2'b00) begin
      dec_d = {a_bit & ~b_bit, ~a_bit & b_bit};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_COLLECT;
      cnt_q       <= '0;
      dec_q       <= 2'b00;
      in_ready_q  <= 1'b0;
      out_valid_q <= 1'b0;
      eq_q        <= 1'b0;
      gt_q        <= 1'b0;
      lt_q        <= 1'b0;
    end else if (clr) begin
      // Abort wins over any beat or result handshake in the same cycle.
      state_q     <= ST_COLLECT;
      cnt_q       <= '0;
      dec_q       <= 2'b00;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      eq_q        <= 1'b0;
      gt_q        <= 1'b0;
      lt_q        <= 1'b0;
    end else begin
      case (state_q)
        ST_COLLECT: begin
          // First edge after reset release raises in_ready.
          in_ready_q <= 1'b1;
          if (beat) begin
            dec_q <= dec_d;
            if (last_beat) begin
              // The final beat is folded straight into the registered result.
              cnt_q       <= '0;
              state_q     <= ST_DONE;
              in_ready_q  <= 1'b0;
              out_valid_q <= 1'b1;
              eq_q        <= (dec_d == 2'b00);
              gt_q        <= (dec_d == 2'b10);
              lt_q        <= (dec_d == 2'b01);
            end else begin
              cnt_q <= cnt_q + 1'b1;
            end
          end
        end
        ST_DONE: begin
          // in_ready stays low in the accept cycle: one bubble per word.
          if (out_ready) begin
            state_q     <= ST_COLLECT;
            dec_q       <= 2'b00;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            eq_q        <= 1'b0;
            gt_q        <= 1'b0;
            lt_q        <= 1'b0;
          end
        end
        default: begin
          state_q <= ST_COLLECT;
        end
      endcase
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign eq        = eq_q;
  assign gt        = gt_q;
  assign lt        = lt_q;
  assign dbg_state = state_q;
  assign dbg_cnt   = cnt_q;

endmodule

// File: tb/tb_serial_mag_comparator.sv
module tb_serial_mag_comparator;

  localparam int WIDTH = 8;
  localparam int CW    = $clog2(WIDTH);

  // result encoding used by the scoreboard: {eq, gt, lt}
  localparam logic [2:0] R_EQ = 3'b100;
  localparam logic [2:0] R_GT = 3'b010;
  localparam logic [2:0] R_LT = 3'b001;

  logic          clk;
  logic          rst_n;
  logic          clr;
  logic          in_valid;
  logic          in_ready;
  logic          a_bit;
  logic          b_bit;
  logic          out_valid;
  logic          out_ready;
  logic          eq;
  logic          gt;
  logic          lt;
  logic          dbg_state;
  logic [CW-1:0] dbg_cnt;

  logic [2:0]    exp_q[$];
  int            n_checks;
  int            n_fail;
  int            cyc;

  serial_mag_comparator #(.WIDTH(WIDTH)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .clr       (clr),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a_bit     (a_bit),
    .b_bit     (b_bit),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .eq        (eq),
    .gt        (gt),
    .lt        (lt),
    .dbg_state (dbg_state),
    .dbg_cnt   (dbg_cnt)
  );

  // ---------------- clock / reset ----------------
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- checking helper ----------------
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- driver tasks ----------------
  // Present one bit pair and hold it until accepted; returns the accept cycle.
  task automatic drive_beat(input logic a, input logic b, output int acc_cyc);
    logic ok;
    int   budget;
    in_valid = 1'b1;
    a_bit    = a;
    b_bit    = b;
    budget   = 0;
    acc_cyc  = -1;
    forever begin
      ok = in_ready;
      @(posedge clk);
      #1;
      if (ok) begin
        acc_cyc = cyc;
        break;
      end
      budget++;
      if (budget > 50) begin
        check("beat_accept_timeout", 32'd0, 32'd1);
        break;
      end
    end
  endtask

  // Stream a full word MSB first; optional stall after beat index stall_after.
  task automatic send_word(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                           input int stall_after, input int stall_len,
                           output int first_cyc);
    int c;
    first_cyc = -1;
    for (int i = WIDTH - 1; i >= 0; i--) begin
      drive_beat(a[i], b[i], c);
      if (i == WIDTH - 1) first_cyc = c;
      if ((WIDTH - 1 - i) == stall_after && stall_len > 0) begin
        in_valid = 1'b0;
        a_bit    = 1'b1;
        b_bit    = 1'b0;
        for (int s = 0; s < stall_len; s++) begin
          check("stall_cnt_hold", 32'(dbg_cnt), 32'(stall_after + 1));
          @(posedge clk);
          #1;
        end
      end
    end
    in_valid = 1'b0;
  endtask

  // ---------------- scoreboard monitor ----------------
  always @(negedge clk) begin
    if (rst_n) begin
      if (out_valid) begin
        check("onehot_result", 32'($countones({eq, gt, lt})), 32'd1);
        if (out_ready) begin
          if (exp_q.size() == 0) begin
            check("unexpected_result", 32'({eq, gt, lt}), 32'd0);
          end else begin
            check("result_eq_gt_lt", 32'({eq, gt, lt}), 32'(exp_q.pop_front()));
          end
        end
      end else begin
        check("idle_flags_zero", 32'({eq, gt, lt}), 32'd0);
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    int f0, f1, f2, dummy, wait_n;
    n_checks  = 0;
    n_fail    = 0;
    rst_n     = 1'b0;
    clr       = 1'b0;
    in_valid  = 1'b0;
    a_bit     = 1'b0;
    b_bit     = 1'b0;
    out_ready = 1'b1;

    // reset state
    #1;
    check("rst_in_ready", 32'(in_ready), 32'd0);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_flags", 32'({eq, gt, lt}), 32'd0);
    check("rst_state", 32'(dbg_state), 32'd0);
    check("rst_cnt", 32'(dbg_cnt), 32'd0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    check("rel_in_ready_before_edge", 32'(in_ready), 32'd0);
    @(posedge clk);
    #1;
    check("rel_in_ready_after_edge", 32'(in_ready), 32'd1);

    // equal operands A=B=A5, latency 1 cycle after last beat
    exp_q.push_back(R_EQ);
    send_word(8'hA5, 8'hA5, -1, 0, f0);
    check("eq_latency_out_valid", 32'(out_valid), 32'd1);
    check("eq_latency_in_ready", 32'(in_ready), 32'd0);
    check("eq_flags", 32'({eq, gt, lt}), 32'(R_EQ));
    @(posedge clk);
    #1;
    check("eq_after_accept_valid", 32'(out_valid), 32'd0);
    check("eq_after_accept_ready", 32'(in_ready), 32'd1);

    // MSB decides: 80 vs 7F, later bits (A=0,B=1) must not flip it
    exp_q.push_back(R_GT);
    send_word(8'h80, 8'h7F, -1, 0, f0);
    check("msb_gt_flags", 32'({eq, gt, lt}), 32'(R_GT));
    @(posedge clk);
    #1;

    // LSB decides with a 3-cycle stall after the 4th beat
    exp_q.push_back(R_LT);
    send_word(8'h00, 8'h01, 3, 3, f0);
    check("lsb_lt_flags", 32'({eq, gt, lt}), 32'(R_LT));
    @(posedge clk);
    #1;

    // backpressure: out_ready low 5 cycles, in_valid asserted in DONE is ignored
    out_ready = 1'b0;
    exp_q.push_back(R_GT);
    send_word(8'h5A, 8'h3C, -1, 0, f0);
    in_valid = 1'b1;
    a_bit    = 1'b1;
    b_bit    = 1'b0;
    for (int k = 0; k < 5; k++) begin
      check("bp_out_valid", 32'(out_valid), 32'd1);
      check("bp_flags_stable", 32'({eq, gt, lt}), 32'(R_GT));
      check("bp_in_ready_low", 32'(in_ready), 32'd0);
      @(posedge clk);
      #1;
    end
    out_ready = 1'b1;
    check("bp_6th_out_valid", 32'(out_valid), 32'd1);
    @(posedge clk);
    #1;
    f1 = cyc;
    check("bp_accepted", 32'(out_valid), 32'd0);
    check("bp_next_in_ready", 32'(in_ready), 32'd1);
    exp_q.push_back(R_EQ);
    send_word(8'h3C, 8'h3C, -1, 0, f0);
    check("bp_next_word_start", 32'(f0), 32'(f1 + 1));
    @(posedge clk);
    #1;

    // clr after 4 beats, then a full word 01 vs 02
    for (int i = 0; i < 4; i++) drive_beat(1'b1, 1'b0, dummy);
    check("abort_cnt_before", 32'(dbg_cnt), 32'd4);
    clr      = 1'b1;
    in_valid = 1'b1;
    a_bit    = 1'b0;
    b_bit    = 1'b1;
    @(posedge clk);
    #1;
    clr      = 1'b0;
    in_valid = 1'b0;
    check("abort_cnt_zero", 32'(dbg_cnt), 32'd0);
    check("abort_state", 32'(dbg_state), 32'd0);
    exp_q.push_back(R_LT);
    send_word(8'h01, 8'h02, -1, 0, f0);
    check("abort_next_lt", 32'({eq, gt, lt}), 32'(R_LT));
    @(posedge clk);
    #1;

    // clr while a result is pending: result is dropped
    out_ready = 1'b0;
    send_word(8'h10, 8'h20, -1, 0, f0);
    check("clr_done_pending", 32'(out_valid), 32'd1);
    clr = 1'b1;
    @(posedge clk);
    #1;
    clr       = 1'b0;
    out_ready = 1'b1;
    check("clr_done_dropped", 32'(out_valid), 32'd0);
    check("clr_done_in_ready", 32'(in_ready), 32'd1);

    // asynchronous reset mid-word
    for (int i = 0; i < 3; i++) drive_beat(1'b0, 1'b1, dummy);
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_in_ready", 32'(in_ready), 32'd0);
    check("arst_out_valid", 32'(out_valid), 32'd0);
    check("arst_flags", 32'({eq, gt, lt}), 32'd0);
    check("arst_cnt", 32'(dbg_cnt), 32'd0);
    in_valid = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check("arst_release_ready", 32'(in_ready), 32'd1);
    exp_q.push_back(R_EQ);
    send_word(8'hC3, 8'hC3, -1, 0, f0);
    check("arst_next_eq", 32'({eq, gt, lt}), 32'(R_EQ));
    @(posedge clk);
    #1;

    // back-to-back gt, lt, eq
    exp_q.push_back(R_GT);
    send_word(8'h40, 8'h3F, -1, 0, f0);
    exp_q.push_back(R_LT);
    send_word(8'h12, 8'h21, -1, 0, f1);
    exp_q.push_back(R_EQ);
    send_word(8'hFF, 8'hFF, -1, 0, f2);
    check("b2b_span_1", 32'(f1 - f0), 32'(WIDTH + 1));
    check("b2b_span_2", 32'(f2 - f1), 32'(WIDTH + 1));

    // drain the scoreboard
    wait_n = 0;
    while (exp_q.size() != 0 && wait_n < 20) begin
      @(posedge clk);
      wait_n++;
    end
    @(posedge clk);
    #1;
    check("scoreboard_drained", 32'(exp_q.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
